morse_playback_ctrl: RTL and testbench

Sequencer that replays the letters held in the Morse storage block on the buzzer, with standard Morse timing. It snapshots the 30-bit storage word (three 10-bit letter sequences) when a playback is requested, walks letter by letter and symbol by symbol, and drives the buzzer and dot/dash indicators. It sits downstream of storage_main and owns the buzzer during playback.

---
 rtl/morse_playback_ctrl.sv | 176 +++++++++++++++++
 tb/tb_morse_playback_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_playback_ctrl.sv
// Morse playback sequencer: snapshots the storage word on an Enter rising edge
// and replays each letter on the buzzer with standard dot/dash/gap timing.
module morse_playback_ctrl #(
    parameter int UNIT_CYCLES = 4,
    parameter int NUM_SEQS    = 3,
    parameter int SEQ_W       = 10
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      Enter,
    input  logic                      Clear,
    input  logic [NUM_SEQS*SEQ_W-1:0] store_seqs,
    input  logic                      storageSent,
    output logic                      buzzer,
    output logic                      dot_active,
    output logic                      dash_active,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                cur_seq
);

    localparam int NUM_SLOTS = SEQ_W / 2;
    localparam int CNT_W     = $clog2(3 * UNIT_CYCLES);
    localparam int SLOT_W    = (NUM_SLOTS > 2) ? $clog2(NUM_SLOTS) : 1;
    localparam int WORD_W    = NUM_SEQS * SEQ_W;

    localparam logic [CNT_W-1:0] UNIT_CNT   = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIPLE_CNT = CNT_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TONE,
        S_GAP,
        S_LGAP,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [1:0]          letter, letter_nx;
    logic [SLOT_W-1:0]   slot, slot_nx;
    logic [WORD_W-1:0]   shadow;
    logic                enter_q;
    logic                rise;
    logic                snap;
    logic [1:0]          cur_sym, nxt_slot_sym, nxt_letter_sym;

    // Out-of-range letter/slot reads as end-of-letter so lookahead never indexes past the word.
    function automatic logic [1:0] sym_at(input logic [WORD_W-1:0] w, input int l, input int s);
        sym_at = 2'b00;
        if (l < NUM_SEQS && s < NUM_SLOTS)
            sym_at = w[(NUM_SEQS-1-l)*SEQ_W + SEQ_W-1-2*s -: 2];
    endfunction

    function automatic logic is_sym(input logic [1:0] v);
        is_sym = (v == 2'b01) || (v == 2'b10);
    endfunction

    function automatic logic [CNT_W-1:0] tone_cnt(input logic [1:0] v);
        tone_cnt = (v == 2'b10) ? TRIPLE_CNT : UNIT_CNT;
    endfunction

    assign rise           = Enter & ~enter_q;
    assign cur_sym        = sym_at(shadow, int'(letter), int'(slot));
    assign nxt_slot_sym   = sym_at(shadow, int'(letter), int'(slot) + 1);
    assign nxt_letter_sym = sym_at(shadow, int'(letter) + 1, 0);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        letter_nx = letter;
        slot_nx   = slot;
        snap      = 1'b0;
        if (Clear) begin
            state_nx  = S_IDLE;
            cnt_nx    = '0;
            letter_nx = '0;
            slot_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    letter_nx = '0;
                    slot_nx   = '0;
                    cnt_nx    = '0;
                    if (rise && storageSent && is_sym(store_seqs[WORD_W-1 -: 2])) begin
                        state_nx = S_LOAD;
                        snap     = 1'b1;
                    end
                end
                // Shadow was captured on the way in; first tone length comes from it.
                S_LOAD: begin
                    state_nx  = S_TONE;
                    letter_nx = '0;
                    slot_nx   = '0;
                    cnt_nx    = tone_cnt(sym_at(shadow, 0, 0));
                end
                S_TONE: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else if (int'(slot) < NUM_SLOTS - 1 && is_sym(nxt_slot_sym)) begin
                        state_nx = S_GAP;
                        cnt_nx   = UNIT_CNT;
                    end else if (int'(letter) < NUM_SEQS - 1 && is_sym(nxt_letter_sym)) begin
                        state_nx = S_LGAP;
                        cnt_nx   = TRIPLE_CNT;
                    end else begin
                        state_nx = S_DONE;
                        cnt_nx   = '0;
                    end
                end
                S_GAP: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else begin
                        state_nx = S_TONE;
                        slot_nx  = slot + SLOT_W'(1);
                        cnt_nx   = tone_cnt(nxt_slot_sym);
                    end
                end
                S_LGAP: begin
                    if (cnt != '0) begin
                        cnt_nx = cnt - CNT_W'(1);
                    end else begin
                        state_nx  = S_TONE;
                        letter_nx = letter + 2'd1;
                        slot_nx   = '0;
                        cnt_nx    = tone_cnt(nxt_letter_sym);
                    end
                end
                S_DONE: begin
                    state_nx  = S_IDLE;
                    letter_nx = '0;
                    slot_nx   = '0;
                end
                default: begin
                    state_nx  = S_IDLE;
                    cnt_nx    = '0;
                    letter_nx = '0;
                    slot_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt     <= '0;
            letter  <= '0;
            slot    <= '0;
            enter_q <= 1'b0;
            shadow  <= '0;
        end else begin
            cnt     <= cnt_nx;
            letter  <= letter_nx;
            slot    <= slot_nx;
            enter_q <= Enter;
            if (snap) shadow <= store_seqs;
        end
    end

    always_comb begin
        buzzer      = (state == S_TONE);
        dot_active  = (state == S_TONE) && (cur_sym == 2'b01);
        dash_active = (state == S_TONE) && (cur_sym == 2'b10);
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        cur_seq     = letter;
    end

endmodule

// File: tb/tb_morse_playback_ctrl.sv
// Scoreboard bench for morse_playback_ctrl: a letter model queues expected
// tone/gap segments, and the monitor measures buzzer runs against them.
module tb_morse_playback_ctrl;

    localparam int U = 4;

    logic        clk = 1'b0;
    logic        Reset, Enter, Clear, storageSent;
    logic [29:0] store_seqs;
    logic        buzzer, dot_active, dash_active, busy, done;
    logic [1:0]  cur_seq;

    typedef struct {
        bit tone;
        int len;
        int seq;
        bit dash;
    } seg_t;

    seg_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    morse_playback_ctrl #(.UNIT_CYCLES(U), .NUM_SEQS(3), .SEQ_W(10)) dut (
        .clk(clk), .Reset(Reset), .Enter(Enter), .Clear(Clear),
        .store_seqs(store_seqs), .storageSent(storageSent),
        .buzzer(buzzer), .dot_active(dot_active), .dash_active(dash_active),
        .busy(busy), .done(done), .cur_seq(cur_seq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Independent Morse model: expected buzzer segments for a storage word.
    task automatic build(input logic [29:0] w);
        seg_t       sg;
        logic [9:0] lt;
        logic [1:0] sy;
        for (int l = 0; l < 3; l++) begin
            lt = w[29-10*l -: 10];
            if (lt[9:8] != 2'b01 && lt[9:8] != 2'b10) break;
            if (l > 0) begin
                sg = '{tone: 1'b0, len: 3*U, seq: l, dash: 1'b0};
                exp_q.push_back(sg);
            end
            for (int s = 0; s < 5; s++) begin
                sy = lt[9-2*s -: 2];
                if (sy != 2'b01 && sy != 2'b10) break;
                if (s > 0) begin
                    sg = '{tone: 1'b0, len: U, seq: l, dash: 1'b0};
                    exp_q.push_back(sg);
                end
                sg = '{tone: 1'b1, len: (sy == 2'b10) ? 3*U : U, seq: l, dash: (sy == 2'b10)};
                exp_q.push_back(sg);
            end
        end
    endtask

    task automatic start(input int hold);
        Enter = 1'b1;
        fork
            begin
                repeat (hold) @(negedge clk);
                Enter = 1'b0;
            end
        join_none
    endtask

    // Entered on the first buzzer-high sample; exits one cycle after done.
    task automatic play_check(input string tag, output int meas);
        seg_t s;
        int   n;
        meas = 0;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            if (s.tone) begin
                chk($sformatf("%s_dot", tag), dot_active, !s.dash);
                chk($sformatf("%s_dash", tag), dash_active, s.dash);
                chk($sformatf("%s_seq", tag), cur_seq, s.seq);
            end
            n = 0;
            while (buzzer === s.tone && n < 200) begin
                n++;
                @(negedge clk);
            end
            chk($sformatf("%s_%s_len", tag, s.tone ? "tone" : "gap"), n, s.len);
            meas += n;
        end
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_busy_done", tag), busy, 1);
        @(negedge clk);
        chk($sformatf("%s_done_fall", tag), done, 0);
        chk($sformatf("%s_busy_fall", tag), busy, 0);
        chk($sformatf("%s_seq_idle", tag), cur_seq, 0);
    endtask

    task automatic play_test(input string tag, input logic [29:0] w, input int hold, output int meas);
        store_seqs  = w;
        storageSent = 1'b1;
        exp_q.delete();
        build(w);
        start(hold);
        @(negedge clk);
        chk($sformatf("%s_busy_load", tag), busy, 1);
        chk($sformatf("%s_buz_load", tag), buzzer, 0);
        @(negedge clk);
        chk($sformatf("%s_buz_first", tag), buzzer, 1);
        play_check(tag, meas);
    endtask

    localparam logic [29:0] SOS  = {10'h150, 10'h2A0, 10'h150};
    localparam logic [29:0] OTL  = {10'h2A0, 10'h000, 10'h150};
    localparam logic [29:0] EMPT = {10'h000, 10'h150, 10'h150};

    initial begin
        int meas;
        int any_busy, any_buz, any_done;

        Reset = 1'b1; Enter = 1'b0; Clear = 1'b0; storageSent = 1'b0; store_seqs = '0;
        repeat (2) @(negedge clk);
        chk("rst_buzzer", buzzer, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dot", dot_active, 0);
        chk("rst_dash", dash_active, 0);
        chk("rst_seq", cur_seq, 0);
        Reset = 1'b0;
        repeat (2) @(negedge clk);

        // SOS
        play_test("sos", SOS, 10, meas);
        chk("sos_done_at", meas, 108);
        repeat (5) @(negedge clk);

        // Single letter then empty; Enter held through DONE must not restart
        play_test("otail", OTL, 100, meas);
        chk("otail_done_at", meas, 44);
        any_busy = 0;
        repeat (40) begin
            @(negedge clk);
            any_busy |= busy;
        end
        chk("otail_no_restart", any_busy, 0);
        repeat (20) @(negedge clk);

        // Not valid, then empty first letter
        store_seqs = SOS; storageSent = 1'b0;
        any_busy = 0; any_buz = 0;
        Enter = 1'b1;
        repeat (20) begin
            @(negedge clk);
            any_busy |= busy; any_buz |= buzzer;
        end
        Enter = 1'b0;
        chk("nv_busy", any_busy, 0);
        chk("nv_buzzer", any_buz, 0);
        @(negedge clk);
        store_seqs = EMPT; storageSent = 1'b1;
        any_busy = 0; any_buz = 0;
        Enter = 1'b1;
        repeat (20) begin
            @(negedge clk);
            any_busy |= busy; any_buz |= buzzer;
        end
        Enter = 1'b0;
        chk("empty_busy", any_busy, 0);
        chk("empty_buzzer", any_buz, 0);
        @(negedge clk);

        // Clear and rise together: Clear wins
        store_seqs = SOS;
        Clear = 1'b1; Enter = 1'b1;
        @(negedge clk);
        chk("clr_rise_busy", busy, 0);
        Clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("clr_rise_stay", busy, 0);
        Enter = 1'b0;
        @(negedge clk);

        // Abort mid-dash, then retrigger
        store_seqs = SOS; storageSent = 1'b1;
        start(10);
        repeat (40) @(negedge clk);
        chk("abort_in_dash", dash_active, 1);
        Clear = 1'b1;
        @(negedge clk);
        chk("abort_buzzer", buzzer, 0);
        chk("abort_busy", busy, 0);
        chk("abort_seq", cur_seq, 0);
        Clear = 1'b0;
        any_done = done; any_busy = 0;
        repeat (30) begin
            @(negedge clk);
            any_done |= done; any_busy |= busy;
        end
        chk("abort_no_done", any_done, 0);
        chk("abort_idle", any_busy, 0);
        play_test("retrig", SOS, 10, meas);
        chk("retrig_done_at", meas, 108);
        repeat (5) @(negedge clk);

        // Isolation: inputs disturbed and Enter re-pulsed mid-playback
        fork
            begin
                repeat (5) @(negedge clk);
                store_seqs  = 30'h0;
                storageSent = 1'b0;
                repeat (25) @(negedge clk);
                Enter = 1'b1;
                repeat (3) @(negedge clk);
                Enter = 1'b0;
            end
        join_none
        play_test("iso", SOS, 2, meas);
        chk("iso_done_at", meas, 108);
        repeat (5) @(negedge clk);

        // Async reset during a tone
        store_seqs = SOS; storageSent = 1'b1;
        start(5);
        repeat (4) @(negedge clk);
        chk("areset_pre_buz", buzzer, 1);
        #1 Reset = 1'b1;
        #1;
        chk("areset_buzzer", buzzer, 0);
        chk("areset_busy", busy, 0);
        chk("areset_dot", dot_active, 0);
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("areset_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
